// File: rtl/port_dispatch_if.sv
// Bundled signals of port_dispatch: packet input, network/CPU output channels and status.
// The master modport is the side that drives packets in; the slave modport is the dispatcher.
interface port_dispatch_if;
    localparam int unsigned DATA_W = 256;
    localparam int unsigned CNT_W  = 32;

    logic              pktout_data_wr;
    logic [DATA_W-1:0] pktout_data;
    logic              pktout_data_valid_wr;
    logic              pktout_data_valid;
    logic              pktout_ready;

    logic              port_data_wr;
    logic [DATA_W-1:0] port_data;
    logic              port_data_valid_wr;
    logic              port_data_valid;
    logic              port_ready;

    logic              cpu_data_wr;
    logic [DATA_W-1:0] cpu_data;
    logic              cpu_data_valid_wr;
    logic              cpu_data_valid;
    logic              cpu_ready;

    logic [CNT_W-1:0]  port_pkt_cnt;
    logic [CNT_W-1:0]  cpu_pkt_cnt;
    logic [CNT_W-1:0]  drop_pkt_cnt;
    logic              ovf_err;

    modport slave (
        input  pktout_data_wr, pktout_data, pktout_data_valid_wr, pktout_data_valid,
        input  port_ready, cpu_ready,
        output pktout_ready,
        output port_data_wr, port_data, port_data_valid_wr, port_data_valid,
        output cpu_data_wr, cpu_data, cpu_data_valid_wr, cpu_data_valid,
        output port_pkt_cnt, cpu_pkt_cnt, drop_pkt_cnt, ovf_err
    );

    modport master (
        output pktout_data_wr, pktout_data, pktout_data_valid_wr, pktout_data_valid,
        output port_ready, cpu_ready,
        input  pktout_ready,
        input  port_data_wr, port_data, port_data_valid_wr, port_data_valid,
        input  cpu_data_wr, cpu_data, cpu_data_valid_wr, cpu_data_valid,
        input  port_pkt_cnt, cpu_pkt_cnt, drop_pkt_cnt, ovf_err
    );
endinterface

// File: rtl/port_dispatch.sv
// Buffers packets in FWFT data/flag FIFOs and dispatches each one, in order, to the
// network port or the CPU port, or discards it, according to its end-of-packet flag.
module port_dispatch #(
    parameter string      PLATFORM = "Xilinx",
    parameter logic [8:0] RDY_TH   = 9'd128
) (
    input  logic           clk,
    input  logic           rst_n,
    port_dispatch_if.slave dp
);
    localparam int unsigned DATA_W  = 256;
    localparam int unsigned CNT_W   = 32;
    localparam int unsigned D_DEPTH = 256;
    localparam int unsigned D_AW    = 8;
    localparam int unsigned D_CW    = D_AW + 1;
    localparam int unsigned F_DEPTH = 128;
    localparam int unsigned F_AW    = 7;
    localparam int unsigned F_CW    = F_AW + 1;

    localparam logic [D_CW-1:0] D_CNT_FULL = D_CW'(D_DEPTH);
    localparam logic [F_CW-1:0] F_CNT_FULL = F_CW'(F_DEPTH);

    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_SEL  = 2'd1;
    localparam logic [1:0] S_SEND = 2'd2;
    localparam logic [1:0] S_DROP = 2'd3;

    localparam logic [1:0] BEAT_TAIL = 2'b10;
    localparam logic       DST_PORT  = 1'b0;
    localparam logic       DST_CPU   = 1'b1;

    logic              fifo_srst_q;
    logic [D_AW-1:0]   d_wp_q, d_rp_q;
    logic [D_CW-1:0]   d_cnt_q;
    logic [F_AW-1:0]   f_wp_q, f_rp_q;
    logic [F_CW-1:0]   f_cnt_q;
    logic              d_push, d_pop, d_full, d_empty;
    logic              f_push, f_pop, f_full, f_empty;
    logic [DATA_W-1:0] d_head;
    logic              f_head;
    logic              head_is_tail, head_is_cpu;

    logic [1:0]        state_q, state_d;
    logic              fwd_q, fwd_d, dst_q, dst_d;
    logic [CNT_W-1:0]  port_cnt_q, port_cnt_d, cpu_cnt_q, cpu_cnt_d, drop_cnt_q, drop_cnt_d;
    logic              ovf_q, ovf_d, rdy_q, rdy_d;
    logic              port_wr_q, port_wr_d, port_vwr_q, port_vwr_d, port_v_q, port_v_d;
    logic              cpu_wr_q, cpu_wr_d, cpu_vwr_q, cpu_vwr_d, cpu_v_q, cpu_v_d;
    logic [DATA_W-1:0] port_data_q, port_data_d, cpu_data_q, cpu_data_d;

    assign d_full  = (d_cnt_q == D_CNT_FULL);
    assign d_empty = (d_cnt_q == '0);
    assign f_full  = (f_cnt_q == F_CNT_FULL);
    assign f_empty = (f_cnt_q == '0);
    assign d_push  = dp.pktout_data_wr & ~d_full;
    assign f_push  = dp.pktout_data_valid_wr & ~f_full;

    assign head_is_tail = (d_head[133:132] == BEAT_TAIL);
    assign head_is_cpu  = (d_head[57:50] == 8'h00) | (d_head[57:50] == 8'h7f);

    // FIFO synchronous reset stays asserted through the first edge after release,
    // the same edge on which pktout_ready first rises.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) fifo_srst_q <= 1'b1;
        else        fifo_srst_q <= 1'b0;
    end

    // Inferred FWFT storage stands in for each vendor's FIFO primitive set.
    if (PLATFORM == "Xilinx") begin : g_xilinx_fifo
        logic [DATA_W-1:0] dmem [D_DEPTH];
        logic              fmem [F_DEPTH];
        always_ff @(posedge clk) begin
            if (d_push) dmem[d_wp_q] <= dp.pktout_data;
            if (f_push) fmem[f_wp_q] <= dp.pktout_data_valid;
        end
        assign d_head = dmem[d_rp_q];
        assign f_head = fmem[f_rp_q];
    end else begin : g_generic_fifo
        logic [DATA_W-1:0] dmem [D_DEPTH];
        logic              fmem [F_DEPTH];
        always_ff @(posedge clk) begin
            if (d_push) dmem[d_wp_q] <= dp.pktout_data;
            if (f_push) fmem[f_wp_q] <= dp.pktout_data_valid;
        end
        assign d_head = dmem[d_rp_q];
        assign f_head = fmem[f_rp_q];
    end

    always_ff @(posedge clk) begin
        if (fifo_srst_q) begin
            d_wp_q  <= '0;
            d_rp_q  <= '0;
            d_cnt_q <= '0;
            f_wp_q  <= '0;
            f_rp_q  <= '0;
            f_cnt_q <= '0;
        end else begin
            if (d_push) d_wp_q <= d_wp_q + D_AW'(1);
            if (d_pop)  d_rp_q <= d_rp_q + D_AW'(1);
            if (f_push) f_wp_q <= f_wp_q + F_AW'(1);
            if (f_pop)  f_rp_q <= f_rp_q + F_AW'(1);
            d_cnt_q <= d_cnt_q + D_CW'(d_push) - D_CW'(d_pop);
            f_cnt_q <= f_cnt_q + F_CW'(f_push) - F_CW'(f_pop);
        end
    end

    // Dispatch FSM; output channel registers are one-cycle pulses that default to zero.
    always_comb begin
        state_d     = state_q;
        fwd_d       = fwd_q;
        dst_d       = dst_q;
        port_cnt_d  = port_cnt_q;
        cpu_cnt_d   = cpu_cnt_q;
        drop_cnt_d  = drop_cnt_q;
        ovf_d       = ovf_q | (dp.pktout_data_wr & d_full);
        rdy_d       = (d_cnt_q < RDY_TH);
        port_wr_d   = 1'b0;
        port_data_d = '0;
        port_vwr_d  = 1'b0;
        port_v_d    = 1'b0;
        cpu_wr_d    = 1'b0;
        cpu_data_d  = '0;
        cpu_vwr_d   = 1'b0;
        cpu_v_d     = 1'b0;
        d_pop       = 1'b0;
        f_pop       = 1'b0;
        case (state_q)
            S_IDLE: begin
                if (!f_empty && !d_empty) begin
                    fwd_d   = f_head;
                    dst_d   = head_is_cpu ? DST_CPU : DST_PORT;
                    f_pop   = 1'b1;
                    state_d = S_SEL;
                end
            end
            S_SEL: begin
                if (!fwd_q) begin
                    state_d = S_DROP;
                end else if ((dst_q == DST_CPU) ? dp.cpu_ready : dp.port_ready) begin
                    state_d = S_SEND;
                end
            end
            S_SEND: begin
                if (!d_empty) begin
                    d_pop = 1'b1;
                    if (dst_q == DST_CPU) begin
                        cpu_wr_d   = 1'b1;
                        cpu_data_d = d_head;
                        cpu_vwr_d  = head_is_tail;
                        cpu_v_d    = head_is_tail;
                    end else begin
                        port_wr_d   = 1'b1;
                        port_data_d = d_head;
                        port_vwr_d  = head_is_tail;
                        port_v_d    = head_is_tail;
                    end
                    if (head_is_tail) begin
                        if (dst_q == DST_CPU) cpu_cnt_d  = cpu_cnt_q + CNT_W'(1);
                        else                  port_cnt_d = port_cnt_q + CNT_W'(1);
                        state_d = S_IDLE;
                    end
                end
            end
            default: begin
                if (!d_empty) begin
                    d_pop = 1'b1;
                    if (head_is_tail) begin
                        drop_cnt_d = drop_cnt_q + CNT_W'(1);
                        state_d    = S_IDLE;
                    end
                end
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= S_IDLE;
            fwd_q       <= 1'b0;
            dst_q       <= DST_PORT;
            port_cnt_q  <= '0;
            cpu_cnt_q   <= '0;
            drop_cnt_q  <= '0;
            ovf_q       <= 1'b0;
            rdy_q       <= 1'b0;
            port_wr_q   <= 1'b0;
            port_data_q <= '0;
            port_vwr_q  <= 1'b0;
            port_v_q    <= 1'b0;
            cpu_wr_q    <= 1'b0;
            cpu_data_q  <= '0;
            cpu_vwr_q   <= 1'b0;
            cpu_v_q     <= 1'b0;
        end else begin
            state_q     <= state_d;
            fwd_q       <= fwd_d;
            dst_q       <= dst_d;
            port_cnt_q  <= port_cnt_d;
            cpu_cnt_q   <= cpu_cnt_d;
            drop_cnt_q  <= drop_cnt_d;
            ovf_q       <= ovf_d;
            rdy_q       <= rdy_d;
            port_wr_q   <= port_wr_d;
            port_data_q <= port_data_d;
            port_vwr_q  <= port_vwr_d;
            port_v_q    <= port_v_d;
            cpu_wr_q    <= cpu_wr_d;
            cpu_data_q  <= cpu_data_d;
            cpu_vwr_q   <= cpu_vwr_d;
            cpu_v_q     <= cpu_v_d;
        end
    end

    assign dp.pktout_ready       = rdy_q;
    assign dp.port_data_wr       = port_wr_q;
    assign dp.port_data          = port_data_q;
    assign dp.port_data_valid_wr = port_vwr_q;
    assign dp.port_data_valid    = port_v_q;
    assign dp.cpu_data_wr        = cpu_wr_q;
    assign dp.cpu_data           = cpu_data_q;
    assign dp.cpu_data_valid_wr  = cpu_vwr_q;
    assign dp.cpu_data_valid     = cpu_v_q;
    assign dp.port_pkt_cnt       = port_cnt_q;
    assign dp.cpu_pkt_cnt        = cpu_cnt_q;
    assign dp.drop_pkt_cnt       = drop_cnt_q;
    assign dp.ovf_err            = ovf_q;
endmodule

// File: tb/tb_port_dispatch.sv
// Randomised and directed bench for port_dispatch: per-channel expected-beat queues and
// packet totals form the reference; a negedge process checks every output cycle.
`timescale 1ns/1ps
module tb_port_dispatch;
    logic clk = 1'b0;
    logic rst_n = 1'b1;
    always #5 clk = ~clk;

    port_dispatch_if dp();
    port_dispatch #(.PLATFORM("Xilinx"), .RDY_TH(9'd128)) dut (.clk(clk), .rst_n(rst_n), .dp(dp));

    int n_vec  = 0;
    int n_miss = 0;

    logic [255:0] exp_port_q[$];
    logic [255:0] exp_cpu_q[$];
    int exp_port_cnt = 0, exp_cpu_cnt = 0, exp_drop_cnt = 0;
    bit exp_ovf = 1'b0;
    int port_beats = 0, cpu_beats = 0;
    bit rand_ready_en = 1'b0;

    task automatic check(input string name, input logic [255:0] act, input logic [255:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_miss++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // Output checker: every beat must be the next expected beat of its channel.
    always @(negedge clk) begin : cmp
        logic [255:0] e;
        bit tail;
        check("one_channel", 256'(dp.port_data_wr & dp.cpu_data_wr), 256'(0));
        if (dp.port_data_wr) begin
            if (exp_port_q.size() == 0) begin
                check("port_unexpected_wr", 256'(dp.port_data_wr), 256'(0));
            end else begin
                e = exp_port_q.pop_front();
                tail = (e[133:132] == 2'b10);
                check("port_data", dp.port_data, e);
                check("port_valid_flags", 256'({dp.port_data_valid_wr, dp.port_data_valid}), 256'({tail, tail}));
                port_beats++;
            end
        end else begin
            check("port_idle_data", dp.port_data, 256'(0));
            check("port_idle_flags", 256'({dp.port_data_valid_wr, dp.port_data_valid}), 256'(0));
        end
        if (dp.cpu_data_wr) begin
            if (exp_cpu_q.size() == 0) begin
                check("cpu_unexpected_wr", 256'(dp.cpu_data_wr), 256'(0));
            end else begin
                e = exp_cpu_q.pop_front();
                tail = (e[133:132] == 2'b10);
                check("cpu_data", dp.cpu_data, e);
                check("cpu_valid_flags", 256'({dp.cpu_data_valid_wr, dp.cpu_data_valid}), 256'({tail, tail}));
                cpu_beats++;
            end
        end else begin
            check("cpu_idle_data", dp.cpu_data, 256'(0));
            check("cpu_idle_flags", 256'({dp.cpu_data_valid_wr, dp.cpu_data_valid}), 256'(0));
        end
        check("ovf_err", 256'(dp.ovf_err), 256'(exp_ovf));
    end

    task automatic tick();
        @(posedge clk);
        #1;
        if (rand_ready_en) begin
            dp.port_ready = ($urandom_range(0, 3) != 0);
            dp.cpu_ready  = ($urandom_range(0, 3) != 0);
        end
    endtask

    function automatic logic [255:0] mk_beat(input logic [1:0] typ, input logic [7:0] id);
        logic [255:0] b;
        for (int w = 0; w < 8; w++) b[w*32 +: 32] = $urandom();
        b[133:132] = typ;
        if (typ == 2'b01) b[57:50] = id;
        return b;
    endfunction

    task automatic send_pkt(input int len, input logic [7:0] id, input bit fwd, input bit gaps);
        logic [255:0] b;
        logic [1:0] typ;
        int guard;
        bit to_cpu, flag_with_tail;
        guard = 0;
        while (dp.pktout_ready !== 1'b1 && guard < 3000) begin
            tick();
            guard++;
        end
        if (guard >= 3000) check("pktout_ready_wait", 256'(dp.pktout_ready), 256'(1));
        to_cpu = (id == 8'h00) || (id == 8'h7f);
        flag_with_tail = gaps && ($urandom_range(0, 1) == 1);
        for (int i = 0; i < len; i++) begin
            typ = (i == 0) ? 2'b01 : ((i == len - 1) ? 2'b10 : 2'b11);
            b = mk_beat(typ, id);
            if (fwd) begin
                if (to_cpu) exp_cpu_q.push_back(b);
                else        exp_port_q.push_back(b);
            end
            dp.pktout_data_wr = 1'b1;
            dp.pktout_data    = b;
            if (i == len - 1 && flag_with_tail) begin
                dp.pktout_data_valid_wr = 1'b1;
                dp.pktout_data_valid    = fwd;
            end
            tick();
            dp.pktout_data_wr       = 1'b0;
            dp.pktout_data_valid_wr = 1'b0;
            dp.pktout_data_valid    = 1'b0;
            if (gaps && $urandom_range(0, 3) == 0) tick();
        end
        if (!flag_with_tail) begin
            dp.pktout_data_valid_wr = 1'b1;
            dp.pktout_data_valid    = fwd;
            tick();
            dp.pktout_data_valid_wr = 1'b0;
            dp.pktout_data_valid    = 1'b0;
        end
        if (!fwd)        exp_drop_cnt++;
        else if (to_cpu) exp_cpu_cnt++;
        else             exp_port_cnt++;
    endtask

    task automatic drain(input int extra);
        int guard;
        guard = 0;
        while ((exp_port_q.size() != 0 || exp_cpu_q.size() != 0) && guard < 20000) begin
            tick();
            guard++;
        end
        if (guard >= 20000) check("drain_wait", 256'(exp_port_q.size() + exp_cpu_q.size()), 256'(0));
        repeat (extra) tick();
    endtask

    task automatic check_counters(input string tag);
        check({tag, "_port_cnt"}, 256'(dp.port_pkt_cnt), 256'(exp_port_cnt));
        check({tag, "_cpu_cnt"},  256'(dp.cpu_pkt_cnt),  256'(exp_cpu_cnt));
        check({tag, "_drop_cnt"}, 256'(dp.drop_pkt_cnt), 256'(exp_drop_cnt));
    endtask

    task automatic enter_reset();
        rst_n = 1'b0;
        exp_port_q.delete();
        exp_cpu_q.delete();
        exp_port_cnt = 0;
        exp_cpu_cnt  = 0;
        exp_drop_cnt = 0;
        exp_ovf      = 1'b0;
        #1;
        check("rst_outputs_wr", 256'({dp.port_data_wr, dp.cpu_data_wr, dp.pktout_ready, dp.ovf_err}), 256'(0));
        check("rst_outputs_valid", 256'({dp.port_data_valid_wr, dp.port_data_valid,
                                         dp.cpu_data_valid_wr, dp.cpu_data_valid}), 256'(0));
        check("rst_port_data", dp.port_data, 256'(0));
        check("rst_cpu_data", dp.cpu_data, 256'(0));
        check("rst_counters", 256'({dp.port_pkt_cnt, dp.cpu_pkt_cnt, dp.drop_pkt_cnt}), 256'(0));
    endtask

    task automatic leave_reset();
        tick();
        rst_n = 1'b1;
        check("ready_before_first_edge", 256'(dp.pktout_ready), 256'(0));
        tick();
        check("ready_after_first_edge", 256'(dp.pktout_ready), 256'(1));
    endtask

    initial begin
        #4_000_000;
        $display("FAIL global_timeout: simulation did not finish");
        $fatal(1);
    end

    initial begin
        int guard;
        dp.pktout_data_wr       = 1'b0;
        dp.pktout_data          = '0;
        dp.pktout_data_valid_wr = 1'b0;
        dp.pktout_data_valid    = 1'b0;
        dp.port_ready           = 1'b1;
        dp.cpu_ready            = 1'b1;
        #1;
        enter_reset();
        repeat (3) tick();
        leave_reset();

        // 4-beat network packet
        send_pkt(4, 8'h05, 1'b1, 1'b0);
        drain(5);
        check("p1_port_pkt_cnt", 256'(dp.port_pkt_cnt), 256'(32'd1));
        check("p1_port_beats", 256'(port_beats), 256'(4));
        check("p1_cpu_beats", 256'(cpu_beats), 256'(0));

        // 2-beat CPU packet
        send_pkt(2, 8'h7f, 1'b1, 1'b0);
        drain(5);
        check("p2_cpu_pkt_cnt", 256'(dp.cpu_pkt_cnt), 256'(32'd1));
        check("p2_cpu_beats", 256'(cpu_beats), 256'(2));
        check("p2_port_beats", 256'(port_beats), 256'(4));

        // 3-beat discarded packet
        send_pkt(3, 8'h22, 1'b0, 1'b0);
        repeat (10) tick();
        check("p3_drop_pkt_cnt", 256'(dp.drop_pkt_cnt), 256'(32'd1));
        check("p3_beats", 256'(port_beats + cpu_beats), 256'(6));

        // Network packet held in SEL by port_ready=0, with a CPU packet queued behind it
        dp.port_ready = 1'b0;
        send_pkt(3, 8'h10, 1'b1, 1'b0);
        send_pkt(2, 8'h00, 1'b1, 1'b0);
        for (int i = 0; i < 10; i++) begin
            tick();
            check("hold_outputs", 256'({dp.port_data_wr, dp.cpu_data_wr}), 256'(0));
        end
        dp.port_ready = 1'b1;
        tick();
        check("hold_release_plus1", 256'(dp.port_data_wr), 256'(0));
        tick();
        check("hold_release_plus2", 256'(dp.port_data_wr), 256'(1));
        drain(5);
        check("hold_port_pkt_cnt", 256'(dp.port_pkt_cnt), 256'(32'd2));
        check("hold_cpu_pkt_cnt", 256'(dp.cpu_pkt_cnt), 256'(32'd2));
        check("hold_beats", 256'(port_beats + cpu_beats), 256'(11));

        // Random traffic with random ready on both outputs
        rand_ready_en = 1'b1;
        for (int p = 0; p < 150; p++) begin
            logic [7:0] id;
            case ($urandom_range(0, 3))
                0:       id = 8'h00;
                1:       id = 8'h7f;
                default: id = 8'($urandom());
            endcase
            send_pkt(int'($urandom_range(2, 24)), id, ($urandom_range(0, 4) != 0), 1'b1);
        end
        rand_ready_en = 1'b0;
        dp.port_ready = 1'b1;
        dp.cpu_ready  = 1'b1;
        drain(400);
        check_counters("rand");

        // Reset while a network packet is being sent
        send_pkt(40, 8'h33, 1'b1, 1'b0);
        guard = 0;
        while (dp.port_data_wr !== 1'b1 && guard < 200) begin
            tick();
            guard++;
        end
        check("midsend_started", 256'(dp.port_data_wr), 256'(1));
        repeat (3) tick();
        enter_reset();
        repeat (3) tick();
        leave_reset();
        repeat (20) tick();
        check("post_rst_port_cnt", 256'(dp.port_pkt_cnt), 256'(32'd0));
        send_pkt(5, 8'h44, 1'b1, 1'b0);
        drain(5);
        check("post_rst_port_pkt_cnt", 256'(dp.port_pkt_cnt), 256'(32'd1));
        check_counters("post_rst");

        // Fill the data FIFO with no flags, then overflow it
        for (int i = 0; i < 128; i++) begin
            dp.pktout_data_wr = 1'b1;
            dp.pktout_data    = mk_beat(2'b11, 8'h00);
            tick();
        end
        dp.pktout_data_wr = 1'b0;
        check("fill128_ready_still", 256'(dp.pktout_ready), 256'(1));
        tick();
        check("fill128_ready_low", 256'(dp.pktout_ready), 256'(0));
        for (int i = 0; i < 129; i++) begin
            dp.pktout_data_wr = 1'b1;
            dp.pktout_data    = mk_beat(2'b11, 8'h00);
            tick();
            if (i == 128) exp_ovf = 1'b1;
        end
        dp.pktout_data_wr = 1'b0;
        tick();
        check("ovf_set", 256'(dp.ovf_err), 256'(1));
        check("ovf_ready_low", 256'(dp.pktout_ready), 256'(0));
        repeat (5) tick();
        check("ovf_sticky", 256'(dp.ovf_err), 256'(1));
        enter_reset();
        repeat (3) tick();
        leave_reset();
        send_pkt(3, 8'h7f, 1'b1, 1'b0);
        drain(5);
        check_counters("final");

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
        $finish;
    end
endmodule
